// File: rtl/sip_dot_xnor_acc_if.sv
// Beat input and group-result output handshake bundle for sip_dot_xnor_acc.
// master = upstream buffers / downstream consumer side, slave = the dot stage.
interface sip_dot_xnor_acc_if #(
  parameter int unsigned N_DOT    = 32,
  parameter int unsigned BITS_ACC = 16,
  parameter int unsigned BITS_CNT = 8
);
  logic                i_Valid;
  logic                o_InReady;
  logic [N_DOT-1:0]    i_Act;
  logic [N_DOT-1:0]    i_Weight;
  logic                i_Mode;
  logic                i_Last;
  logic                o_Valid;
  logic                i_Ready;
  logic [BITS_ACC-1:0] o_Result;
  logic [BITS_CNT-1:0] o_Beats;
  logic                o_Sat;

  modport master (
    output i_Valid, i_Act, i_Weight, i_Mode, i_Last, i_Ready,
    input  o_InReady, o_Valid, o_Result, o_Beats, o_Sat
  );

  modport slave (
    input  i_Valid, i_Act, i_Weight, i_Mode, i_Last, i_Ready,
    output o_InReady, o_Valid, o_Result, o_Beats, o_Sat
  );
endinterface

// File: rtl/sip_dot_xnor_acc.sv
// Pipelined AND / XNOR(+-1) dot product with saturating per-group accumulation.
// Optional macro SIP_DOT_TREE_PIPE_EN registers the lane-pair partial sums (one extra cycle).
module sip_dot_xnor_acc #(
  parameter int unsigned N_DOT    = 32,
  parameter int unsigned BITS_ACC = 16,
  parameter int unsigned BITS_CNT = 8
) (
  input logic              i_CLK,
  input logic              i_RST,
  sip_dot_xnor_acc_if.slave bus
);
  localparam int unsigned BITS_SUM  = $clog2(N_DOT) + 2;
  localparam int unsigned BITS_WIDE = BITS_ACC + 1;
  localparam int unsigned N_PAIR    = N_DOT / 2;
  localparam logic [BITS_ACC-1:0] ACC_MAX = {1'b0, {(BITS_ACC-1){1'b1}}};
  localparam logic [BITS_ACC-1:0] ACC_MIN = {1'b1, {(BITS_ACC-1){1'b0}}};

  logic en;
  logic accept;
  logic out_valid;
  logic signed [BITS_ACC-1:0] out_result;
  logic [BITS_CNT-1:0] out_beats;
  logic out_sat;

  // Single stall domain: every stage advances only when the result register can move.
  assign en            = !out_valid || bus.i_Ready;
  assign accept        = bus.i_Valid && en;
  assign bus.o_InReady = en;
  assign bus.o_Valid   = out_valid;
  assign bus.o_Result  = out_result;
  assign bus.o_Beats   = out_beats;
  assign bus.o_Sat     = out_sat;

  logic signed [1:0] prod [N_DOT];
  logic signed [2:0] pair [N_PAIR];

  // Lane products (AND: 0/1, XNOR: +1/-1) and the first tree level of pair sums.
  always_comb begin
    for (int i = 0; i < N_DOT; i++) begin
      prod[i] = '0;
      if (bus.i_Mode) begin
        prod[i] = (bus.i_Act[i] == bus.i_Weight[i]) ? 2'sb01 : 2'sb11;
      end else begin
        prod[i] = {1'b0, bus.i_Act[i] & bus.i_Weight[i]};
      end
    end
    for (int j = 0; j < N_PAIR; j++) begin
      pair[j] = 3'(prod[2*j]) + 3'(prod[2*j+1]);
    end
  end

  logic signed [2:0] tree_in [N_PAIR];
  logic tree_valid;
  logic tree_last;

`ifdef SIP_DOT_TREE_PIPE_EN
  logic signed [2:0] pair_q [N_PAIR];
  logic p_valid;
  logic p_last;

  // Mid-tree register: holds the N_DOT/2 pair partials of an accepted beat.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      for (int j = 0; j < N_PAIR; j++) pair_q[j] <= '0;
    end else if (en) begin
      p_valid <= accept;
      if (accept) begin
        pair_q <= pair;
        p_last <= bus.i_Last;
      end
    end
  end

  always_comb begin
    tree_in    = pair_q;
    tree_valid = p_valid;
    tree_last  = p_last;
  end
`else
  always_comb begin
    tree_in    = pair;
    tree_valid = accept;
    tree_last  = bus.i_Last;
  end
`endif

  logic signed [BITS_SUM-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < N_PAIR; j++) begin
      tree_sum = tree_sum + BITS_SUM'(tree_in[j]);
    end
  end

  logic s1_valid;
  logic s1_last;
  logic signed [BITS_SUM-1:0] s1_sum;

  // S1: registered beat sum.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (en) begin
      s1_valid <= tree_valid;
      if (tree_valid) begin
        s1_sum  <= tree_sum;
        s1_last <= tree_last;
      end
    end
  end

  logic signed [BITS_ACC-1:0]  acc;
  logic [BITS_CNT-1:0]         cnt;
  logic                        sat;
  logic signed [BITS_WIDE-1:0] acc_wide;
  logic signed [BITS_ACC-1:0]  acc_next;
  logic [BITS_CNT-1:0]         cnt_next;
  logic                        clamp;
  logic                        sat_next;

  // One guard bit is enough because a beat sum always fits in BITS_ACC.
  always_comb begin
    acc_wide = BITS_WIDE'(acc) + BITS_WIDE'(s1_sum);
    clamp    = acc_wide[BITS_ACC] != acc_wide[BITS_ACC-1];
    acc_next = acc_wide[BITS_ACC-1:0];
    if (clamp) acc_next = acc_wide[BITS_ACC] ? ACC_MIN : ACC_MAX;
    cnt_next = (&cnt) ? cnt : cnt + BITS_CNT'(1);
    sat_next = sat || clamp;
  end

  // S2: accumulate; a closing beat loads the result register and restarts the group.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_beats  <= '0;
      out_sat    <= 1'b0;
    end else if (en) begin
      if (s1_valid && s1_last) begin
        out_valid  <= 1'b1;
        out_result <= acc_next;
        out_beats  <= cnt_next;
        out_sat    <= sat_next;
        acc        <= '0;
        cnt        <= '0;
        sat        <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (s1_valid) begin
          acc <= acc_next;
          cnt <= cnt_next;
          sat <= sat_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_sip_dot_xnor_acc.sv
// Directed bench for sip_dot_xnor_acc: a 16-bit and an 8-bit accumulator instance share stimulus.
module tb_sip_dot_xnor_acc;
`ifdef SIP_DOT_TREE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst;
  logic valid, mode, last, ready;
  logic [31:0] act, wt;
  int checks = 0;
  int errors = 0;

  sip_dot_xnor_acc_if #(.N_DOT(32), .BITS_ACC(16), .BITS_CNT(8)) bus_a ();
  sip_dot_xnor_acc_if #(.N_DOT(32), .BITS_ACC(8),  .BITS_CNT(8)) bus_s ();

  assign bus_a.i_Valid  = valid;
  assign bus_a.i_Act    = act;
  assign bus_a.i_Weight = wt;
  assign bus_a.i_Mode   = mode;
  assign bus_a.i_Last   = last;
  assign bus_a.i_Ready  = ready;
  assign bus_s.i_Valid  = valid;
  assign bus_s.i_Act    = act;
  assign bus_s.i_Weight = wt;
  assign bus_s.i_Mode   = mode;
  assign bus_s.i_Last   = last;
  assign bus_s.i_Ready  = ready;

  sip_dot_xnor_acc #(.N_DOT(32), .BITS_ACC(16), .BITS_CNT(8)) dut_a (
    .i_CLK(clk), .i_RST(rst), .bus(bus_a.slave));
  sip_dot_xnor_acc #(.N_DOT(32), .BITS_ACC(8), .BITS_CNT(8)) dut_s (
    .i_CLK(clk), .i_RST(rst), .bus(bus_s.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns the number of stalled cycles.
  task automatic send(input logic [31:0] a, input logic [31:0] w, input logic m,
                      input logic l, output int stalls);
    logic acc_now;
    bit done;
    act = a; wt = w; mode = m; last = l; valid = 1'b1;
    stalls = 0;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      acc_now = bus_a.o_InReady;
      tick();
      if (acc_now) done = 1;
      else stalls++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: beat not accepted within 100 cycles");
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (bus_a.o_Valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; act = '1; wt = '1; mode = 1'b1; last = 1'b1; ready = 1'b0;
    repeat (3) tick();
    checks++; if (bus_a.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.o_Valid); end
    checks++; if (bus_a.o_Result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", bus_a.o_Result); end
    checks++; if (bus_a.o_Beats !== 8'h00) begin errors++; $display("FAIL reset_beats: got %h want 00", bus_a.o_Beats); end
    checks++; if (bus_a.o_Sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", bus_a.o_Sat); end
    checks++; if (bus_a.o_InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b want 1", bus_a.o_InReady); end
    valid = 1'b0; last = 1'b0; rst = 1'b0; ready = 1'b1;
    repeat (4) tick();
    checks++; if (bus_a.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_no_stale: got %b want 0", bus_a.o_Valid); end
  endtask

  // Latency is counted from the edge before the beat is presented.
  task automatic test_xnor_single();
    act = '1; wt = '1; mode = 1'b1; last = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    repeat (LAT - 2) tick();
    checks++; if (bus_a.o_Valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus_a.o_Valid); end
    tick();
    checks++; if (bus_a.o_Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus_a.o_Valid); end
    checks++; if (bus_a.o_Result !== 16'd32) begin errors++; $display("FAIL single_result: got %0d want 32", $signed(bus_a.o_Result)); end
    checks++; if (bus_a.o_Beats !== 8'd1) begin errors++; $display("FAIL single_beats: got %0d want 1", bus_a.o_Beats); end
    tick();
    checks++; if (bus_a.o_Valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b want 0", bus_a.o_Valid); end
  endtask

  task automatic test_xnor_mismatch();
    int st;
    bit ok;
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 32'h0, 1'b1, i == 2, st);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mismatch_timeout: no result"); end
    checks++; if (bus_a.o_Result !== 16'hFFA0) begin errors++; $display("FAIL mismatch_result: got %0d want -96", $signed(bus_a.o_Result)); end
    checks++; if (bus_a.o_Beats !== 8'd3) begin errors++; $display("FAIL mismatch_beats: got %0d want 3", bus_a.o_Beats); end
    checks++; if (bus_a.o_Sat !== 1'b0) begin errors++; $display("FAIL mismatch_sat: got %b want 0", bus_a.o_Sat); end
    tick();
  endtask

  task automatic test_and_mode();
    int st;
    bit ok;
    for (int i = 0; i < 4; i++) send(32'h0000_FFFF, 32'h00FF_00FF, 1'b0, i == 3, st);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL and_timeout: no result"); end
    checks++; if (bus_a.o_Result !== 16'd32) begin errors++; $display("FAIL and_result: got %0d want 32", $signed(bus_a.o_Result)); end
    checks++; if (bus_a.o_Beats !== 8'd4) begin errors++; $display("FAIL and_beats: got %0d want 4", bus_a.o_Beats); end
    checks++; if (bus_a.o_Sat !== 1'b0) begin errors++; $display("FAIL and_sat: got %b want 0", bus_a.o_Sat); end
    tick();
  endtask

  // Groups: +32+32=64 | AND popcount 4 | 0+32+16=48 | 24-8=16
  task automatic test_back_to_back();
    logic [31:0] av [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] wv [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000};
    logic        mv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        lv [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] er [4] = '{16'd64, 16'd4, 16'd48, 16'd16};
    logic [7:0]  eb [4] = '{8'd2, 8'd1, 8'd3, 8'd1};
    int total_stalls = 0;
    ready = 1'b1;
    fork
      begin
        int st;
        for (int i = 0; i < 7; i++) begin
          send(av[i], wv[i], mv[i], lv[i], st);
          total_stalls += st;
        end
      end
      begin
        bit ok;
        for (int k = 0; k < 4; k++) begin
          wait_valid(ok);
          checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: group %0d missing", k); end
          checks++; if (bus_a.o_Result !== er[k]) begin errors++; $display("FAIL b2b_result: group %0d got %0d want %0d", k, $signed(bus_a.o_Result), $signed(er[k])); end
          checks++; if (bus_a.o_Beats !== eb[k]) begin errors++; $display("FAIL b2b_beats: group %0d got %0d want %0d", k, bus_a.o_Beats, eb[k]); end
          tick();
        end
      end
    join
    checks++; if (total_stalls != 0) begin errors++; $display("FAIL b2b_bubble: got %0d stalls want 0", total_stalls); end
  endtask

  task automatic test_backpressure();
    int st;
    bit ok;
    ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, st);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, st);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: first group missing"); end
    act = 32'hFFFF_FFFF; wt = 32'hFFFF_FF00; mode = 1'b1; last = 1'b0; valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus_a.o_InReady !== 1'b0) begin errors++; $display("FAIL bp_inready: cycle %0d got %b want 0", c, bus_a.o_InReady); end
      checks++; if (bus_a.o_Valid !== 1'b1 || bus_a.o_Result !== 16'd64) begin errors++; $display("FAIL bp_hold: cycle %0d got v=%b r=%0d want v=1 r=64", c, bus_a.o_Valid, $signed(bus_a.o_Result)); end
      tick();
    end
    ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 1'b0, st);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, st);
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, st);
    wait_valid(ok);
    checks++; if (!ok || bus_a.o_Result !== 16'd48 || bus_a.o_Beats !== 8'd2) begin errors++; $display("FAIL bp_group2: got r=%0d b=%0d want r=48 b=2", $signed(bus_a.o_Result), bus_a.o_Beats); end
    tick();
    wait_valid(ok);
    checks++; if (!ok || bus_a.o_Result !== 16'd1 || bus_a.o_Beats !== 8'd1) begin errors++; $display("FAIL bp_group3: got r=%0d b=%0d want r=1 b=1", $signed(bus_a.o_Result), bus_a.o_Beats); end
    tick();
  endtask

  task automatic test_saturation();
    int st;
    bit ok;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, i == 4, st);
    wait_valid(ok);
    checks++; if (!ok || bus_s.o_Result !== 8'd127 || bus_s.o_Sat !== 1'b1) begin errors++; $display("FAIL sat_pos: got r=%0d s=%b want r=127 s=1", $signed(bus_s.o_Result), bus_s.o_Sat); end
    checks++; if (bus_s.o_Beats !== 8'd5) begin errors++; $display("FAIL sat_beats: got %0d want 5", bus_s.o_Beats); end
    checks++; if (bus_a.o_Result !== 16'd160 || bus_a.o_Sat !== 1'b0) begin errors++; $display("FAIL wide_no_sat: got r=%0d s=%b want r=160 s=0", $signed(bus_a.o_Result), bus_a.o_Sat); end
    tick();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, st);
    wait_valid(ok);
    checks++; if (!ok || bus_s.o_Result !== 8'd32 || bus_s.o_Sat !== 1'b0) begin errors++; $display("FAIL sat_cleared: got r=%0d s=%b want r=32 s=0", $signed(bus_s.o_Result), bus_s.o_Sat); end
    tick();
    for (int i = 0; i < 5; i++) send(32'hFFFF_FFFF, 32'h0, 1'b1, i == 4, st);
    wait_valid(ok);
    checks++; if (!ok || bus_s.o_Result !== 8'h80 || bus_s.o_Sat !== 1'b1) begin errors++; $display("FAIL sat_neg: got r=%0d s=%b want r=-128 s=1", $signed(bus_s.o_Result), bus_s.o_Sat); end
    checks++; if (bus_a.o_Result !== 16'hFF60) begin errors++; $display("FAIL wide_neg: got %0d want -160", $signed(bus_a.o_Result)); end
    tick();
  endtask

  task automatic test_reset_mid_group();
    int st;
    bit ok;
    bit seen = 0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, st);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, st);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus_a.o_Valid !== 1'b0 || bus_s.o_Valid !== 1'b0) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_output: got a result want none"); end
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, st);
    wait_valid(ok);
    checks++; if (!ok || bus_a.o_Result !== 16'd32 || bus_a.o_Beats !== 8'd1) begin errors++; $display("FAIL midrst_fresh: got r=%0d b=%0d want r=32 b=1", $signed(bus_a.o_Result), bus_a.o_Beats); end
    checks++; if (bus_s.o_Result !== 8'd32 || bus_s.o_Sat !== 1'b0) begin errors++; $display("FAIL midrst_fresh_s: got r=%0d s=%b want r=32 s=0", $signed(bus_s.o_Result), bus_s.o_Sat); end
    tick();
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mode = 1'b0; last = 1'b0; ready = 1'b0; act = '0; wt = '0;
    test_reset();
    test_xnor_single();
    test_xnor_mismatch();
    test_and_mode();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_group();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
